// File: rtl/cam_init_pkg.sv
// Shared types and constants for the camera register-initialisation sequencer.
// Entries are {reg_addr[15:0], value[7:0]}; address DELAY_MARKER makes the value a wait in ms.
package cam_init_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_DELAY,
    ST_SEND,
    ST_WAIT,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [15:0] DELAY_MARKER     = 16'hFFFF;
  localparam int          ENTRY_W          = 24;
  localparam int          DEFAULT_NUM_REGS = 64;

  function automatic logic is_delay(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_W-1:8] == DELAY_MARKER;
  endfunction

endpackage

// File: rtl/cam_reg_rom.sv
// Camera register table (VGA RGB565 bring-up); one-cycle registered read, no backpressure.
// Unused indices read as a zero-length delay so they never drive a bus write.
module cam_reg_rom
  import cam_init_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_index,
  output logic [ENTRY_W-1:0] o_entry
);

  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] r_entry;

  always_comb begin
    w_entry = {DELAY_MARKER, 8'h00};
    case (i_index)
      8'd0:  w_entry = 24'h310311;
      8'd1:  w_entry = 24'h300882;
      8'd2:  w_entry = 24'h300842;
      8'd3:  w_entry = {DELAY_MARKER, 8'd5};  // sensor needs 5 ms after soft reset
      8'd4:  w_entry = 24'h310303;
      8'd5:  w_entry = 24'h3017ff;
      8'd6:  w_entry = 24'h3018ff;
      8'd7:  w_entry = 24'h30341a;
      8'd8:  w_entry = 24'h303721;
      8'd9:  w_entry = 24'h310801;
      8'd10: w_entry = 24'h363036;
      8'd11: w_entry = 24'h36310e;
      8'd12: w_entry = 24'h3632e2;
      8'd13: w_entry = 24'h363312;
      8'd14: w_entry = 24'h3621e0;
      8'd15: w_entry = 24'h3704a0;
      8'd16: w_entry = 24'h37035a;
      8'd17: w_entry = 24'h371578;
      8'd18: w_entry = 24'h371701;
      8'd19: w_entry = 24'h370b60;
      8'd20: w_entry = 24'h37051a;
      8'd21: w_entry = 24'h390502;
      8'd22: w_entry = 24'h390610;
      8'd23: w_entry = 24'h39010a;
      8'd24: w_entry = 24'h373112;
      8'd25: w_entry = 24'h360008;
      8'd26: w_entry = 24'h360133;
      8'd27: w_entry = 24'h302d60;
      8'd28: w_entry = 24'h362052;
      8'd29: w_entry = 24'h371b20;
      8'd30: w_entry = 24'h471c50;
      8'd31: w_entry = 24'h3a1343;
      8'd32: w_entry = 24'h3a1800;
      8'd33: w_entry = 24'h3a19f8;
      8'd34: w_entry = 24'h363513;
      8'd35: w_entry = 24'h363603;
      8'd36: w_entry = 24'h363440;
      8'd37: w_entry = 24'h362201;
      8'd38: w_entry = 24'h3c0134;
      8'd39: w_entry = 24'h3c0428;
      8'd40: w_entry = 24'h3c0598;
      8'd41: w_entry = 24'h3c0600;
      8'd42: w_entry = 24'h3c0708;
      8'd43: w_entry = 24'h3c0800;
      8'd44: w_entry = 24'h3c091c;
      8'd45: w_entry = 24'h3c0a9c;
      8'd46: w_entry = 24'h3c0b40;
      8'd47: w_entry = 24'h382047;
      8'd48: w_entry = 24'h382101;
      8'd49: w_entry = 24'h381428;
      8'd50: w_entry = 24'h381531;
      8'd51: w_entry = 24'h380000;
      8'd52: w_entry = 24'h380100;
      8'd53: w_entry = 24'h380200;
      8'd54: w_entry = 24'h380304;
      8'd55: w_entry = 24'h38040a;
      8'd56: w_entry = 24'h38053f;
      8'd57: w_entry = 24'h380607;
      8'd58: w_entry = 24'h38079b;
      8'd59: w_entry = 24'h380802;  // output width 640
      8'd60: w_entry = 24'h380980;
      8'd61: w_entry = 24'h380a01;  // output height 480
      8'd62: w_entry = 24'h380be0;
      8'd63: w_entry = 24'h430061;
      default: w_entry = {DELAY_MARKER, 8'h00};
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_entry <= '0;
    end else begin
      r_entry <= w_entry;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/cam_init_seq.sv
// Walks the camera register table through the i2c byte-writer, retrying NACKed or stalled writes.
// First write POWERUP_CYCLES+3 cycles after start; each write waits on the writer's done; start ignored while busy.
module cam_init_seq
  import cam_init_pkg::*;
#(
  parameter int NUM_REGS       = DEFAULT_NUM_REGS,
  parameter int POWERUP_CYCLES = 500000,
  parameter int MS_CYCLES      = 25000,
  parameter int TIMEOUT_CYCLES = 16384,
  parameter int MAX_RETRY      = 3
) (
  input  logic        meg25,
  input  logic        reset_n,
  input  logic        start,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic [23:0] i2c_dat,
  output logic        i2c_sendit,
  output logic        i2c_reset,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic [7:0]  err_index
);

  localparam logic [31:0] PWRUP_LOAD = 32'(POWERUP_CYCLES);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]  END_INDEX  = 9'(NUM_REGS);
  localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);
  localparam logic        NO_REGS    = (NUM_REGS == 0);

  state_t             r_state;
  logic [8:0]         r_index;
  logic [7:0]         r_retry;
  logic [31:0]        r_cnt;
  logic               r_nack;
  logic [23:0]        r_dat;
  logic               r_sendit;
  logic               r_i2c_reset;
  logic               r_busy;
  logic               r_init_done;
  logic               r_init_err;
  logic [7:0]         r_err_index;

  logic [1:0]         r_done_sync;
  logic [1:0]         r_ack_sync;
  logic               r_done_q;

  logic               w_done;
  logic               w_done_rise;
  logic               w_ack;
  logic [ENTRY_W-1:0] w_rom_entry;
  logic [31:0]        w_delay_cycles;

  cam_reg_rom u_rom (
    .i_clk   (meg25),
    .i_rst_n (reset_n),
    .i_index (r_index[7:0]),
    .o_entry (w_rom_entry)
  );

  // The writer runs on derived clocks, so its handshake is resynchronised here.
  always_ff @(posedge meg25 or negedge reset_n) begin
    if (!reset_n) begin
      r_done_sync <= '0;
      r_ack_sync  <= '0;
      r_done_q    <= 1'b0;
    end else begin
      r_done_sync <= {r_done_sync[0], i2c_done};
      r_ack_sync  <= {r_ack_sync[0], i2c_ack};
      r_done_q    <= r_done_sync[1];
    end
  end

  assign w_done         = r_done_sync[1];
  assign w_done_rise    = w_done & ~r_done_q;
  assign w_ack          = r_ack_sync[1];
  assign w_delay_cycles = 32'(w_rom_entry[7:0]) * 32'(MS_CYCLES);

  always_ff @(posedge meg25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_nack      <= 1'b0;
      r_dat       <= '0;
      r_sendit    <= 1'b0;
      r_i2c_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
      r_err_index <= '0;
    end else begin
      r_i2c_reset <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_init_done <= 1'b0;
            r_init_err  <= 1'b0;
            r_err_index <= '0;
            r_busy      <= 1'b1;
            r_index     <= '0;
            r_retry     <= '0;
            r_cnt       <= PWRUP_LOAD;
            r_state     <= ST_PWRUP;
          end
        end

        ST_PWRUP: begin
          if (r_cnt <= 32'd1) begin
            if (NO_REGS) begin
              r_init_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_FETCH;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end

        // The ROM output now reflects r_index, which has been stable for at least one cycle.
        ST_FETCH: begin
          if (is_delay(w_rom_entry)) begin
            r_cnt   <= w_delay_cycles;
            r_state <= ST_DELAY;
          end else begin
            r_state <= ST_SEND;
          end
        end

        ST_DELAY: begin
          if (r_cnt == 32'd0) begin
            r_index <= r_index + 9'd1;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end

        ST_SEND: begin
          r_dat    <= w_rom_entry;
          r_sendit <= 1'b1;
          r_cnt    <= '0;
          r_state  <= ST_WAIT;
        end

        ST_WAIT: begin
          if (w_done_rise) begin
            r_nack   <= w_ack;
            r_sendit <= 1'b0;
            r_state  <= ST_CHECK;
          end else if (r_cnt >= TMO_LAST) begin
            r_nack   <= 1'b1;
            r_sendit <= 1'b0;
            r_state  <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        ST_CHECK: begin
          if (!r_nack) begin
            r_retry <= '0;
            r_index <= r_index + 9'd1;
            r_state <= ST_GAP;
          end else if (r_retry < RETRY_MAX) begin
            r_i2c_reset <= 1'b1;
            r_retry     <= r_retry + 8'd1;
            r_state     <= ST_GAP;
          end else begin
            r_err_index <= r_index[7:0];
            r_init_err  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_ERR;
          end
        end

        ST_GAP: begin
          if (!w_done) begin
            if (r_index == END_INDEX) begin
              r_init_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign i2c_dat    = r_dat;
  assign i2c_sendit = r_sendit;
  assign i2c_reset  = r_i2c_reset;
  assign busy       = r_busy;
  assign init_done  = r_init_done;
  assign init_err   = r_init_err;
  assign err_index  = r_err_index;

endmodule

// File: doc/cam_init_seq.md
# cam_init_seq

Camera register-initialisation sequencer for the VGA camera path. After power-up delay it walks a table of 24-bit register writes (16-bit register address, 8-bit value), hands each one to the `i2c` byte-writer through its `sendit`/`done`/`ack` handshake, retries NACKed or stalled transfers, and reports completion or failure to the video pipeline.

## Interface
- `NUM_REGS`, 64: table entries executed, indices 0..NUM_REGS-1 (max 256).
- `POWERUP_CYCLES`, 500000: `meg25` cycles waited after `start` before the first write (20 ms).
- `MS_CYCLES`, 25000: cycles per millisecond for delay entries.
- `TIMEOUT_CYCLES`, 16384: per-transfer watchdog (one transfer ≈ 5418 cycles).
- `MAX_RETRY`, 3: extra attempts per entry after the first failure.
- `meg25  in  1  25 MHz system clock`
- `reset_n  in  1  asynchronous, active-low reset`
- `start  in  1  single-cycle pulse; begins a sequence from index 0`
- `i2c_done  in  1  from i2c `done``
- `i2c_ack  in  1  from i2c `ack`; 1 = NACK seen`
- `i2c_dat  out  24  {reg_addr[15:0], value[7:0]} to i2c `send_dat``
- `i2c_sendit  out  1  to i2c `sendit``
- `i2c_reset  out  1  one-cycle pulse to i2c `reset` (clears its ack flag)`
- `busy  out  1  sequence in progress`
- `init_done  out  1  sticky: all entries written`
- `init_err  out  1  sticky: entry failed after retries`
- `err_index  out  8  index of failing entry`

## Operation
- Reset: all outputs 0, state IDLE, index 0, retry 0.
- `i2c_done`, `i2c_ack` pass through 2-flop synchronisers (writer runs on derived clocks); only synced versions used.
- States: IDLE → PWRUP → FETCH → (DELAY | SEND) → WAIT → CHECK → GAP → FETCH …; terminal DONE, ERR.
- IDLE: on `start`, clear `init_done`/`init_err`/`err_index`, busy=1, → PWRUP.
- PWRUP: count POWERUP_CYCLES, → FETCH.
- FETCH: read ROM[index] (1-cycle latency). Address 16'hFFFF is a delay marker → DELAY for value×MS_CYCLES cycles (value 0 = no wait), then advance. Otherwise → SEND.
- SEND: latch entry onto `i2c_dat`, assert `i2c_sendit`, clear watchdog, → WAIT. `i2c_dat` stable while `i2c_sendit`=1.
- WAIT: on synced `i2c_done` rising: sample synced `i2c_ack`, drop `i2c_sendit`, → CHECK. Watchdog reaching TIMEOUT_CYCLES: drop `i2c_sendit`, treat as NACK.
- CHECK: success → retry=0, index+1. Failure with retry<MAX_RETRY → pulse `i2c_reset`, retry+1, same index. Failure with retry=MAX_RETRY → `err_index`=index, `init_err`=1, → ERR.
- GAP: wait for synced `i2c_done`=0 (writer idle); then index=NUM_REGS → DONE (`init_done`=1) else FETCH.
- DONE/ERR: busy=0; `start` restarts from IDLE behaviour. `start` while busy ignored.
- `reset_n` low mid-transfer: `i2c_sendit` drops asynchronously; writer abandons frame.

## Timing
- `start` → busy=1 next cycle; first `i2c_sendit` POWERUP_CYCLES+3 cycles later.
- `i2c_done` rise → `i2c_sendit` fall: 3 cycles (2 sync + 1).
- `i2c_reset` pulse exactly 1 cycle, issued in CHECK, before re-entering SEND.
- `init_done`/`init_err` set same cycle busy falls; mutually exclusive.
- Index, retry counters never wrap; NUM_REGS=0 goes PWRUP→DONE with no transfer.

## Structure
- Package `cam_init_pkg`: state enum, `DELAY_MARKER`=16'hFFFF, entry width 24, default table length.
- Sub-module `cam_reg_rom`: registered-output case ROM of camera register settings, index in, 24-bit entry out.
- Synchronisers, watchdog, delay and power-up counters inline (shared down-counter acceptable).

## Test plan
- NUM_REGS=3, writer model ACKs all: `start` → three transfers with `i2c_dat` 0x310311, 0x300882, 0x300842; `init_done`=1, busy=0.
- Entry 1 NACKed once: one `i2c_reset` pulse, entry 1 resent, `init_done`=1, `init_err`=0.
- Entry 2 NACKed 4 times (MAX_RETRY=3): exactly 4 attempts, `init_err`=1, `err_index`=2, no entry 3 sent.
- Writer never raises `done`: `i2c_sendit` drops after TIMEOUT_CYCLES, 4 attempts, then `init_err`=1.
- Entry {16'hFFFF, 8'd5} with MS_CYCLES=10: 50-cycle gap, no `i2c_sendit`, next entry follows.
- `reset_n` low during WAIT: `i2c_sendit`, busy, flags 0 immediately; `start` after release replays from index 0.
